// File: rtl/fork_cond_n_r1_2ph_pkg.sv
// rtl/fork_cond_n_r1_2ph_pkg.sv - shared types and reset values for the 2-phase conditional fork
package fork_cond_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_PHASE = 1'b0;
  localparam logic   RST_FLAG  = 1'b0;

  // Advance the 2-phase request of every selected channel.
  function automatic logic [31:0] toggle_sel(input logic [31:0] phases, input logic [31:0] sel);
    return phases ^ sel;
  endfunction

endpackage

// File: rtl/fork_cond_n_r1_2ph_if.sv
// rtl/fork_cond_n_r1_2ph_if.sv - input channel, output channels and status of the conditional fork
interface fork_cond_n_r1_2ph_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic             r;
  logic             a;
  logic [WIDTH-1:0] d_in;
  logic [N-1:0]     cond;
  logic [N-1:0]     r_n;
  logic [N-1:0]     a_n;
  logic [WIDTH-1:0] d_out;
  logic             busy;
  logic             err;

  modport master (
    output r, d_in, cond, a_n,
    input  a, r_n, d_out, busy, err
  );

  modport slave (
    input  r, d_in, cond, a_n,
    output a, r_n, d_out, busy, err
  );
endinterface

// File: rtl/sync_2ph_bit.sv
// rtl/sync_2ph_bit.sv - single-bit synchroniser for 2-phase signals, STAGES=0 passes through
module sync_2ph_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_wire
      assign q = d;
    end else begin : g_sync
      logic [STAGES-1:0] ff;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          ff <= '0;
        end else begin
          ff[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            ff[i] <= ff[i-1];
          end
        end
      end

      assign q = ff[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/fork_cond_n_r1_2ph.sv
// rtl/fork_cond_n_r1_2ph.sv - clocked N-channel conditional fork for 2-phase req/ack with data bundle
module fork_cond_n_r1_2ph
  import fork_cond_pkg::*;
#(
  parameter int N           = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  fork_cond_n_r1_2ph_if.slave   bus
);

  logic             r_s;
  logic [N-1:0]     a_s;

  state_t           state_q, state_d;
  logic             r_ph_q, r_ph_d;
  logic [N-1:0]     sel_q, sel_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             a_q, a_d;
  logic [N-1:0]     rn_q, rn_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [N-1:0]     mismatch;
  logic [N-1:0]     pending;

  sync_2ph_bit #(.STAGES(SYNC_STAGES)) u_sync_r (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.r),
    .q    (r_s)
  );

  generate
    for (genvar i = 0; i < N; i++) begin : g_ack_sync
      sync_2ph_bit #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk  (clk),
        .rstn (rstn),
        .d    (bus.a_n[i]),
        .q    (a_s[i])
      );
    end
  endgenerate

  // A channel is outstanding while its ack phase trails its request phase.
  assign mismatch = a_s ^ rn_q;
  assign pending  = sel_q & mismatch;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= RST_STATE;
      r_ph_q  <= RST_PHASE;
      sel_q   <= '0;
      dout_q  <= '0;
      a_q     <= RST_PHASE;
      rn_q    <= '0;
      busy_q  <= RST_FLAG;
      err_q   <= RST_FLAG;
    end else begin
      state_q <= state_d;
      r_ph_q  <= r_ph_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      a_q     <= a_d;
      rn_q    <= rn_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_ph_d  = r_ph_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    a_d     = a_q;
    rn_d    = rn_q;
    busy_d  = busy_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (mismatch != '0) begin
          err_d = 1'b1;
        end
        if (r_s != r_ph_q) begin
          r_ph_d = r_s;
          dout_d = bus.d_in;
          sel_d  = bus.cond;
          if (bus.cond != '0) begin
            rn_d    = N'(toggle_sel(32'(rn_q), 32'(bus.cond)));
            busy_d  = 1'b1;
            state_d = WAIT;
          end else begin
            a_d = ~a_q;
          end
        end
      end

      WAIT: begin
        // An early request stays unaccepted here; IDLE picks it up after the ack.
        if (((mismatch & ~sel_q) != '0) || (r_s != r_ph_q)) begin
          err_d = 1'b1;
        end
        if (pending == '0) begin
          a_d     = ~a_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.a     = a_q;
  assign bus.r_n   = rn_q;
  assign bus.d_out = dout_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_fork_cond_n_r1_2ph.sv
// tb/tb_fork_cond_n_r1_2ph.sv - directed and randomised checks of the 2-phase conditional fork
module tb_fork_cond_n_r1_2ph;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  fork_cond_n_r1_2ph_if #(.N(N), .WIDTH(W)) bus ();

  fork_cond_n_r1_2ph #(.N(N), .WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int   a_toggles = 0;
  logic a_last    = 1'b0;

  always @(negedge clk) begin
    if (bus.a !== a_last) a_toggles++;
    a_last = bus.a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a(input logic prev, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.a !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rn(input logic [N-1:0] prev, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.r_n !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic env_reset();
    rstn     = 1'b0;
    bus.r    = 1'b0;
    bus.a_n  = '0;
    bus.cond = '0;
    bus.d_in = '0;
    tick();
    rstn = 1'b1;
    tick();
    tick();
  endtask

  logic         ok;
  logic         ea;
  logic [N-1:0] ern;
  logic [N-1:0] c;
  logic [W-1:0] dv;
  int           base;
  int           rcount;

  initial begin
    // 1: reset with random inputs
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.r    = 1'($urandom);
      bus.a_n  = N'($urandom);
      bus.cond = N'($urandom);
      bus.d_in = W'($urandom);
      tick();
    end
    check("rst_a", 32'(bus.a), 32'h0);
    check("rst_rn", 32'(bus.r_n), 32'h0);
    check("rst_dout", 32'(bus.d_out), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    bus.r = 1'b0; bus.a_n = '0; bus.cond = '0; bus.d_in = '0;
    rstn = 1'b1;
    repeat (3) tick();
    check("idle_err", 32'(bus.err), 32'h0);

    // 2: two selected channels, acks out of order
    bus.d_in = 8'hA5; bus.cond = 4'b1010; bus.r = 1'b1;
    tick(); tick();
    check("t2_rn_early", 32'(bus.r_n), 32'h0);
    tick();
    check("t2_rn", 32'(bus.r_n), 32'hA);
    check("t2_dout", 32'(bus.d_out), 32'hA5);
    check("t2_busy", 32'(bus.busy), 32'h1);
    repeat (4) tick();
    bus.a_n[3] = 1'b1;
    repeat (5) tick();
    bus.a_n[1] = 1'b1;
    tick(); tick();
    check("t2_a_early", 32'(bus.a), 32'h0);
    check("t2_busy_hold", 32'(bus.busy), 32'h1);
    tick();
    check("t2_a", 32'(bus.a), 32'h1);
    check("t2_busy_done", 32'(bus.busy), 32'h0);

    // 3: empty selection acks directly
    bus.d_in = 8'h5A; bus.cond = 4'b0000; bus.r = 1'b0;
    tick(); tick();
    check("t3_a_early", 32'(bus.a), 32'h1);
    check("t3_busy_mid", 32'(bus.busy), 32'h0);
    tick();
    check("t3_a", 32'(bus.a), 32'h0);
    check("t3_rn", 32'(bus.r_n), 32'hA);
    check("t3_busy", 32'(bus.busy), 32'h0);
    check("t3_dout", 32'(bus.d_out), 32'h5A);

    // 4: all channels, simultaneous acks
    bus.d_in = 8'hC3; bus.cond = 4'b1111; bus.r = 1'b1;
    repeat (3) tick();
    check("t4_rn", 32'(bus.r_n), 32'h5);
    check("t4_busy", 32'(bus.busy), 32'h1);
    tick();
    bus.a_n = 4'b0101;
    tick(); tick();
    check("t4_a_early", 32'(bus.a), 32'h0);
    tick();
    check("t4_a", 32'(bus.a), 32'h1);
    check("t4_busy_done", 32'(bus.busy), 32'h0);

    // 5a: request toggles again while busy
    bus.d_in = 8'h3C; bus.cond = 4'b0001; bus.r = 1'b0;
    repeat (3) tick();
    check("t5a_rn", 32'(bus.r_n), 32'h4);
    check("t5a_err_clean", 32'(bus.err), 32'h0);
    bus.d_in = 8'h77; bus.cond = 4'b0010; bus.r = 1'b1;
    repeat (3) tick();
    check("t5a_err", 32'(bus.err), 32'h1);
    check("t5a_rn_hold", 32'(bus.r_n), 32'h4);
    check("t5a_dout_hold", 32'(bus.d_out), 32'h3C);
    bus.a_n[0] = 1'b0;
    repeat (3) tick();
    check("t5a_a", 32'(bus.a), 32'h0);
    check("t5a_busy_gap", 32'(bus.busy), 32'h0);
    tick();
    check("t5a_rn2", 32'(bus.r_n), 32'h6);
    check("t5a_dout2", 32'(bus.d_out), 32'h77);
    check("t5a_busy2", 32'(bus.busy), 32'h1);
    bus.a_n[1] = 1'b1;
    repeat (3) tick();
    check("t5a_a2", 32'(bus.a), 32'h1);

    // 5b: ack on an unselected channel
    env_reset();
    check("t5b_err_reset", 32'(bus.err), 32'h0);
    bus.d_in = 8'h11; bus.cond = 4'b0001; bus.r = 1'b1;
    repeat (3) tick();
    check("t5b_rn", 32'(bus.r_n), 32'h1);
    bus.a_n[2] = 1'b1;
    tick(); tick();
    check("t5b_err_early", 32'(bus.err), 32'h0);
    tick();
    check("t5b_err", 32'(bus.err), 32'h1);
    bus.a_n[0] = 1'b1;
    repeat (3) tick();
    check("t5b_a", 32'(bus.a), 32'h1);

    // 6: reset in WAIT with two acks outstanding
    env_reset();
    bus.d_in = 8'h99; bus.cond = 4'b0011; bus.r = 1'b1;
    repeat (3) tick();
    check("t6_busy", 32'(bus.busy), 32'h1);
    check("t6_rn", 32'(bus.r_n), 32'h3);
    rstn = 1'b0; bus.r = 1'b0; bus.a_n = '0; bus.cond = '0;
    tick();
    check("t6_a", 32'(bus.a), 32'h0);
    check("t6_rn_rst", 32'(bus.r_n), 32'h0);
    check("t6_dout", 32'(bus.d_out), 32'h0);
    check("t6_busy_rst", 32'(bus.busy), 32'h0);
    check("t6_err", 32'(bus.err), 32'h0);
    rstn = 1'b1;
    tick(); tick();

    // random transactions against a phase model
    base   = a_toggles;
    rcount = 0;
    ea     = 1'b0;
    ern    = '0;
    for (int t = 0; t < 200; t++) begin
      c  = N'($urandom_range(0, 15));
      dv = W'($urandom);
      bus.cond = c; bus.d_in = dv; bus.r = ~bus.r;
      rcount++;
      if (c == '0) begin
        wait_a(ea, ok);
        check("rnd_ack0_seen", 32'(ok), 32'h1);
        ea = ~ea;
        check("rnd_ack0_a", 32'(bus.a), 32'(ea));
        check("rnd_ack0_rn", 32'(bus.r_n), 32'(ern));
        check("rnd_ack0_dout", 32'(bus.d_out), 32'(dv));
      end else begin
        wait_rn(ern, ok);
        check("rnd_req_seen", 32'(ok), 32'h1);
        ern = ern ^ c;
        check("rnd_rn", 32'(bus.r_n), 32'(ern));
        check("rnd_dout", 32'(bus.d_out), 32'(dv));
        for (int i = 0; i < N; i++) begin
          if (c[i]) begin
            repeat ($urandom_range(0, 3)) tick();
            bus.a_n[i] = ~bus.a_n[i];
          end
        end
        wait_a(ea, ok);
        check("rnd_ack_seen", 32'(ok), 32'h1);
        ea = ~ea;
        check("rnd_a", 32'(bus.a), 32'(ea));
        check("rnd_busy", 32'(bus.busy), 32'h0);
      end
    end
    tick(); tick();
    check("rnd_err", 32'(bus.err), 32'h0);
    check("rnd_count", 32'(a_toggles - base), 32'(rcount));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
